// File: rtl/sincos_var_window_avg.sv
// sincos_var_window_avg
//   Dual-channel (SIN/COS) moving-sum filter with a runtime-selectable window
//   of DELAY+1 samples. Feeds TOP_* and UPDATE_REQ to the autoscale block and
//   takes DELAY / DELAY_UPDATED back from it. Full-width sums go downstream.
//
// Ports
//   CLK, RESET     clock, asynchronous active-high reset
//   CE             clock enable; 0 holds every register
//   IN_SIN/IN_COS  signed input samples, accepted when CE=1
//   DELAY          requested window minus 1, taken on CE & DELAY_UPDATED
//   DELAY_UPDATED  one-cycle pulse: new DELAY present
//   OUT_SIN/COS    registered signed windowed sums
//   TOP_SIN/COS    top TOP_DATA_BITS of OUT_SIN/OUT_COS
//   OUT_VALID      window fully populated
//   UPDATE_REQ     one-cycle request to the autoscale block
//
// State | meaning
// ------+--------------------------------------------------------------
// FILL  | window not yet populated; samples are only added
// RUN   | window full; each sample added, oldest removed, periodic request

module sincos_var_window_avg #(
  parameter int DATA_BITS     = 16,
  parameter int DELAY_BITS    = 4,
  parameter int TOP_DATA_BITS = 4,
  parameter int INIT_DELAY    = 1
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                CE,
  input  logic signed [DATA_BITS-1:0]         IN_SIN,
  input  logic signed [DATA_BITS-1:0]         IN_COS,
  input  logic        [DELAY_BITS-1:0]        DELAY,
  input  logic                                DELAY_UPDATED,
  output logic signed [DATA_BITS+DELAY_BITS-1:0] OUT_SIN,
  output logic signed [DATA_BITS+DELAY_BITS-1:0] OUT_COS,
  output logic        [TOP_DATA_BITS-1:0]     TOP_SIN,
  output logic        [TOP_DATA_BITS-1:0]     TOP_COS,
  output logic                                OUT_VALID,
  output logic                                UPDATE_REQ
);

  localparam int DEPTH    = 1 << DELAY_BITS;
  localparam int ACC_BITS = DATA_BITS + DELAY_BITS;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_BITS-1:0]  mem_sin [DEPTH];
  logic [DATA_BITS-1:0]  mem_cos [DEPTH];

  logic [0:0]            state;
  logic [DELAY_BITS-1:0] wptr;
  logic [DELAY_BITS-1:0] rd_addr;
  logic [DELAY_BITS-1:0] active_delay;
  logic [DELAY_BITS-1:0] run_cnt;
  logic [DELAY_BITS:0]   fill_cnt;
  logic [DELAY_BITS:0]   win_len;
  logic                  removing;
  logic                  fill_done;

  logic signed [ACC_BITS-1:0] acc_sin;
  logic signed [ACC_BITS-1:0] acc_cos;
  logic signed [ACC_BITS-1:0] in_sin_ext;
  logic signed [ACC_BITS-1:0] in_cos_ext;
  logic signed [ACC_BITS-1:0] rm_sin_ext;
  logic signed [ACC_BITS-1:0] rm_cos_ext;
  logic signed [ACC_BITS-1:0] sum_sin_next;
  logic signed [ACC_BITS-1:0] sum_cos_next;

  assign win_len = {1'b0, active_delay} + (DELAY_BITS+1)'(1);

  // wptr - N modulo depth; at N = depth this is wptr itself, read before write.
  assign rd_addr = wptr - active_delay - DELAY_BITS'(1);

  assign in_sin_ext = {{DELAY_BITS{IN_SIN[DATA_BITS-1]}}, IN_SIN};
  assign in_cos_ext = {{DELAY_BITS{IN_COS[DATA_BITS-1]}}, IN_COS};
  assign rm_sin_ext = {{DELAY_BITS{mem_sin[rd_addr][DATA_BITS-1]}}, mem_sin[rd_addr]};
  assign rm_cos_ext = {{DELAY_BITS{mem_cos[rd_addr][DATA_BITS-1]}}, mem_cos[rd_addr]};

  // FILL can already hold a full window when the new window is N=1: the
  // sample taken with DELAY_UPDATED must then be dropped on the next sample.
  assign removing  = (state == ST_RUN) || (fill_cnt >= win_len);
  assign fill_done = fill_cnt >= (win_len - (DELAY_BITS+1)'(1));

  assign sum_sin_next = acc_sin + in_sin_ext - (removing ? rm_sin_ext : '0);
  assign sum_cos_next = acc_cos + in_cos_ext - (removing ? rm_cos_ext : '0);

  always_ff @(posedge CLK) begin
    if (CE) begin
      mem_sin[wptr] <= IN_SIN;
      mem_cos[wptr] <= IN_COS;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_FILL;
      wptr         <= '0;
      active_delay <= DELAY_BITS'(INIT_DELAY);
      fill_cnt     <= '0;
      run_cnt      <= '0;
      acc_sin      <= '0;
      acc_cos      <= '0;
      OUT_VALID    <= 1'b0;
      UPDATE_REQ   <= 1'b0;
    end else if (CE) begin
      wptr       <= wptr + DELAY_BITS'(1);
      UPDATE_REQ <= 1'b0;
      if (DELAY_UPDATED) begin
        // the sample in this cycle opens the new window
        active_delay <= DELAY;
        acc_sin      <= in_sin_ext;
        acc_cos      <= in_cos_ext;
        fill_cnt     <= (DELAY_BITS+1)'(1);
        run_cnt      <= '0;
        state        <= ST_FILL;
        OUT_VALID    <= 1'b0;
      end else begin
        acc_sin <= sum_sin_next;
        acc_cos <= sum_cos_next;
        if (state == ST_FILL) begin
          if (fill_done) begin
            state      <= ST_RUN;
            OUT_VALID  <= 1'b1;
            UPDATE_REQ <= 1'b1;
            run_cnt    <= '0;
          end else begin
            fill_cnt <= fill_cnt + (DELAY_BITS+1)'(1);
          end
        end else begin
          run_cnt <= run_cnt + DELAY_BITS'(1);
          if (run_cnt == '1) begin
            UPDATE_REQ <= 1'b1;
          end
        end
      end
    end else begin
      UPDATE_REQ <= 1'b0;
    end
  end

  assign OUT_SIN = acc_sin;
  assign OUT_COS = acc_cos;
  assign TOP_SIN = acc_sin[ACC_BITS-1 -: TOP_DATA_BITS];
  assign TOP_COS = acc_cos[ACC_BITS-1 -: TOP_DATA_BITS];

endmodule

// File: tb/tb_sincos_var_window_avg.sv
// Directed bench for sincos_var_window_avg: a vector table of hand-computed
// sums plus sequences for full-scale, CE gating and asynchronous reset.

module tb_sincos_var_window_avg;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               CE;
  logic               DELAY_UPDATED;
  logic [3:0]         DELAY;
  logic signed [15:0] IN_SIN;
  logic signed [15:0] IN_COS;
  logic signed [19:0] OUT_SIN;
  logic signed [19:0] OUT_COS;
  logic [3:0]         TOP_SIN;
  logic [3:0]         TOP_COS;
  logic               OUT_VALID;
  logic               UPDATE_REQ;

  int checks = 0;
  int errors = 0;

  sincos_var_window_avg #(
    .DATA_BITS(16), .DELAY_BITS(4), .TOP_DATA_BITS(4), .INIT_DELAY(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_SIN(IN_SIN), .IN_COS(IN_COS),
    .DELAY(DELAY), .DELAY_UPDATED(DELAY_UPDATED),
    .OUT_SIN(OUT_SIN), .OUT_COS(OUT_COS), .TOP_SIN(TOP_SIN), .TOP_COS(TOP_COS),
    .OUT_VALID(OUT_VALID), .UPDATE_REQ(UPDATE_REQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit ce; bit upd; int dly; int s; int c;
    int e_s; int e_c; bit e_v; bit e_r;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit ce, bit upd, int dly, int s, int c,
                              int e_s, int e_c, bit e_v, bit e_r);
    vec_t v;
    v.ce = ce; v.upd = upd; v.dly = dly; v.s = s; v.c = c;
    v.e_s = e_s; v.e_c = e_c; v.e_v = e_v; v.e_r = e_r;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit ce, input bit upd, input int dly,
                       input int s, input int c);
    CE = ce; DELAY_UPDATED = upd; DELAY = 4'(dly);
    IN_SIN = 16'(s); IN_COS = 16'(c);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int e_s, input int e_c,
                         input bit e_v, input bit e_r);
    chk({tag, " out_sin"}, OUT_SIN, e_s);
    chk({tag, " out_cos"}, OUT_COS, e_c);
    chk({tag, " valid"}, {31'b0, OUT_VALID}, {31'b0, e_v});
    chk({tag, " update_req"}, {31'b0, UPDATE_REQ}, {31'b0, e_r});
  endtask

  function automatic int win_sum(ref int q[$], input int n);
    int acc = 0;
    int k0 = (q.size() > n) ? q.size() - n : 0;
    for (int k = k0; k < q.size(); k++) acc += q[k];
    return acc;
  endfunction

  int hs[$];
  int hc[$];

  initial begin
    int n, s, c, len;
    bit ce;
    int m_s, m_c;
    bit m_v, m_r;

    // reset window N=2: 100,200,200..; then N=4 with zeros then tens
    add(1,0,0, 100,-5,  100, -5, 0,0);
    add(1,0,0, 100,-5,  200,-10, 1,1);
    add(1,0,0, 100,-5,  200,-10, 1,0);
    add(1,0,0, 100,-5,  200,-10, 1,0);
    add(1,1,3,   0, 3,    0,  3, 0,0);
    add(1,0,0,   0, 3,    0,  6, 0,0);
    add(1,0,0,   0, 3,    0,  9, 0,0);
    add(1,0,0,   0, 3,    0, 12, 1,1);
    add(1,0,0,  10, 3,   10, 12, 1,0);
    add(1,0,0,  10, 3,   20, 12, 1,0);
    add(1,0,0,  10, 3,   30, 12, 1,0);
    add(1,0,0,  10, 3,   40, 12, 1,0);
    add(1,0,0,  10, 3,   40, 12, 1,0);
    // DELAY_UPDATED without CE is ignored; window stays N=4
    add(0,1,0,  99,99,   40, 12, 1,0);
    add(1,0,0,  10, 3,   40, 12, 1,0);
    // switch to N=6 while running
    add(1,1,5,   7,-1,    7, -1, 0,0);
    add(1,0,0,   7,-1,   14, -2, 0,0);
    add(1,0,0,   7,-1,   21, -3, 0,0);
    add(1,0,0,   7,-1,   28, -4, 0,0);
    add(1,0,0,   7,-1,   35, -5, 0,0);
    add(1,0,0,   7,-1,   42, -6, 1,1);
    for (int k = 1; k <= 17; k++) add(1,0,0, 7,-1, 42,-6, 1, k == 16);
    // N=1
    add(1,1,0,   5, 0,    5,  0, 0,0);
    add(1,0,0,   9, 2,    9,  2, 1,1);
    add(1,0,0,  -3, 4,   -3,  4, 1,0);
    // update coinciding with fill completion: update wins
    add(1,1,1,   1, 1,    1,  1, 0,0);
    add(1,1,1,   2, 2,    2,  2, 0,0);
    add(1,0,0,   3, 3,    5,  5, 1,1);

    RESET = 1'b1; CE = 1'b0; DELAY_UPDATED = 1'b0; DELAY = '0;
    IN_SIN = '0; IN_COS = '0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    chk("reset top_sin", {28'b0, TOP_SIN}, 0);
    chk("reset top_cos", {28'b0, TOP_COS}, 0);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ce, vecs[i].upd, vecs[i].dly, vecs[i].s, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].e_s, vecs[i].e_c,
              vecs[i].e_v, vecs[i].e_r);
    end

    // full-scale window N=16
    drive(1, 1, 15, -32768, 32767);
    for (int k = 2; k <= 15; k++) drive(1, 0, 0, -32768, 32767);
    chk("fs valid before 16th", {31'b0, OUT_VALID}, 0);
    drive(1, 0, 0, -32768, 32767);
    chk_all("fs", -524288, 524272, 1, 1);
    chk("fs top_sin", {28'b0, TOP_SIN}, 32'sd8);
    chk("fs top_cos", {28'b0, TOP_COS}, 32'sd7);

    // random CE gating against a sample-history model, window N=3
    n = 3;
    hs.delete(); hc.delete();
    s = 123; c = -77;
    drive(1, 1, 2, s, c);
    hs.push_back(s); hc.push_back(c);
    m_s = s; m_c = c; m_v = 0; m_r = 0;
    chk_all("rnd start", m_s, m_c, m_v, m_r);
    for (int k = 0; k < 120; k++) begin
      ce = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 4000)) - 2000;
      c = int'($urandom_range(0, 4000)) - 2000;
      drive(ce, 0, 0, s, c);
      if (ce) begin
        hs.push_back(s); hc.push_back(c);
        len = hs.size();
        m_s = win_sum(hs, n);
        m_c = win_sum(hc, n);
        m_v = len >= n;
        m_r = (len == n) || (len > n && ((len - n) % 16) == 0);
      end else begin
        m_r = 0;
      end
      chk_all($sformatf("rnd%0d", k), m_s, m_c, m_v, m_r);
    end

    // asynchronous reset in the middle of a fill (N=8)
    drive(1, 1, 7, 1, 2);
    drive(1, 0, 0, 2, 2);
    chk_all("prefill", 3, 4, 0, 0);
    RESET = 1'b1;
    #1;
    chk_all("async reset", 0, 0, 0, 0);
    #1;
    RESET = 1'b0;
    drive(1, 0, 0, 50, -50);
    chk_all("post reset 1", 50, -50, 0, 0);
    drive(1, 0, 0, 60, -60);
    chk_all("post reset 2", 110, -110, 1, 1);
    drive(1, 0, 0, 70, -70);
    chk_all("post reset 3", 130, -130, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
